band_scheduler: RTL and testbench

BAND_SCHEDULER -- requirements
Module: band_scheduler

---
 rtl/band_sched_pkg.sv | 43 ++++
 rtl/band_scheduler_peak_decay.sv | 25 ++
 rtl/band_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_band_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/band_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : band_sched_pkg                                               |
// | Description : Shared types, widths and helpers for the band scheduler.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package band_sched_pkg;

  localparam int NUM_BANDS              = 7;
  localparam int MAG_W                  = 8;
  localparam int BAND_W                 = 3;
  localparam int SHIFT_W                = 3;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1023;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef struct packed {
    logic              found;
    logic [BAND_W-1:0] idx;
  } band_pick_t;

  // Lowest enabled band whose index is >= from; found=0 when none remains.
  function automatic band_pick_t next_band(input logic [NUM_BANDS-1:0] mask,
                                           input logic [BAND_W:0]      from);
    band_pick_t pick;
    pick = '0;
    for (int i = NUM_BANDS - 1; i >= 0; i--) begin
      if (mask[i] && ((BAND_W+1)'(i) >= from)) begin
        pick.found = 1'b1;
        pick.idx   = BAND_W'(i);
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/band_scheduler_peak_decay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : peak_decay                                                   |
// | Description : Peak-hold level update: max(mag, old - (old >> shift)).      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module peak_decay
  import band_sched_pkg::*;
(
  input  logic [MAG_W-1:0]   old_level,
  input  logic [MAG_W-1:0]   mag,
  input  logic [SHIFT_W-1:0] shift,
  output logic [MAG_W-1:0]   new_level
);

  logic [MAG_W-1:0] decayed;

  // old >> shift never exceeds old, so the subtraction cannot wrap.
  always_comb begin
    decayed   = old_level - (old_level >> shift);
    new_level = (mag > decayed) ? mag : decayed;
  end

endmodule
`default_nettype wire

// File: rtl/band_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : band_scheduler                                               |
// | Description : Sequences up to seven bands per audio frame through a shared |
// |               band-filter engine and keeps peak-hold display levels.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module band_scheduler
  import band_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int SAMPLE_W       = 18
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                ready,
  input  logic [SAMPLE_W-1:0] audio_in,
  input  logic [9:0]          controls,
  output logic                eng_start,
  output logic [BAND_W-1:0]   eng_band,
  output logic [SAMPLE_W-1:0] eng_sample,
  input  logic                eng_done,
  input  logic [MAG_W-1:0]    eng_mag,
  output logic [MAG_W-1:0]    freq1,
  output logic [MAG_W-1:0]    freq2,
  output logic [MAG_W-1:0]    freq3,
  output logic [MAG_W-1:0]    freq4,
  output logic [MAG_W-1:0]    freq5,
  output logic [MAG_W-1:0]    freq6,
  output logic [MAG_W-1:0]    freq7,
  output logic [SAMPLE_W-1:0] audio_out,
  output logic                audio_valid,
  output logic                busy,
  output logic [7:0]          overrun_cnt,
  output logic                timeout_err
);

  localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [BAND_W-1:0]     band_q, band_d;
  logic [SAMPLE_W-1:0]   sample_q, sample_d;
  logic [NUM_BANDS-1:0]  mask_q, mask_d;
  logic [SHIFT_W-1:0]    shift_q, shift_d;
  logic [MAG_W-1:0]      mag_q, mag_d;
  logic [CNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [MAG_W-1:0]      freq_q [NUM_BANDS];
  logic [MAG_W-1:0]      freq_d [NUM_BANDS];
  logic [SAMPLE_W-1:0]   audio_out_q, audio_out_d;
  logic                  audio_valid_q, audio_valid_d;
  logic                  eng_start_q, eng_start_d;
  logic [7:0]            overrun_q, overrun_d;
  logic                  timeout_err_q, timeout_err_d;

  logic                  accept;
  band_pick_t            pick;
  logic [MAG_W-1:0]      cur_level;
  logic [MAG_W-1:0]      upd_level;

  // Current level of the band being processed, fed to the shared decay unit.
  always_comb begin
    cur_level = '0;
    for (int k = 0; k < NUM_BANDS; k++) begin
      if (band_q == BAND_W'(k)) cur_level = freq_q[k];
    end
  end

  peak_decay u_peak_decay (
    .old_level (cur_level),
    .mag       (mag_q),
    .shift     (shift_q),
    .new_level (upd_level)
  );

  // Next-state and datapath updates for the frame sequencer.
  always_comb begin
    state_d       = state_q;
    band_d        = band_q;
    sample_d      = sample_q;
    mask_d        = mask_q;
    shift_d       = shift_q;
    mag_d         = mag_q;
    tmo_cnt_d     = tmo_cnt_q;
    freq_d        = freq_q;
    audio_out_d   = audio_out_q;
    audio_valid_d = 1'b0;
    eng_start_d   = 1'b0;
    overrun_d     = overrun_q;
    timeout_err_d = timeout_err_q;
    accept        = 1'b0;
    pick          = '0;

    case (state_q)
      ST_IDLE: begin
        if (ready) accept = 1'b1;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_done) begin
          mag_d     = eng_mag;
          tmo_cnt_d = '0;
          state_d   = ST_UPDATE;
        end else if (tmo_cnt_q == CNT_LAST) begin
          mag_d         = '0;
          tmo_cnt_d     = '0;
          timeout_err_d = 1'b1;
          state_d       = ST_UPDATE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_UPDATE: begin
        for (int k = 0; k < NUM_BANDS; k++) begin
          if (band_q == BAND_W'(k)) freq_d[k] = upd_level;
        end
        pick = next_band(mask_q, {1'b0, band_q} + 1'b1);
        if (pick.found) begin
          band_d      = pick.idx;
          eng_start_d = 1'b1;
          state_d     = ST_ISSUE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Clearing uses the finishing frame's mask, even if a new frame starts now.
        for (int k = 0; k < NUM_BANDS; k++) begin
          if (!mask_q[k]) freq_d[k] = '0;
        end
        audio_out_d   = sample_q;
        audio_valid_d = 1'b1;
        state_d       = ST_IDLE;
        if (ready) accept = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobes arriving while a frame is in flight are dropped and counted.
    if (ready && ((state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_UPDATE))) begin
      if (overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
    end

    if (accept) begin
      sample_d = audio_in;
      mask_d   = controls[6:0];
      shift_d  = controls[9:7];
      pick     = next_band(controls[6:0], '0);
      if (pick.found) begin
        band_d      = pick.idx;
        eng_start_d = 1'b1;
        state_d     = ST_ISSUE;
      end else begin
        state_d = ST_DONE;
      end
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      band_q        <= '0;
      sample_q      <= '0;
      mask_q        <= '0;
      shift_q       <= '0;
      mag_q         <= '0;
      tmo_cnt_q     <= '0;
      for (int k = 0; k < NUM_BANDS; k++) freq_q[k] <= '0;
      audio_out_q   <= '0;
      audio_valid_q <= 1'b0;
      eng_start_q   <= 1'b0;
      overrun_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      band_q        <= band_d;
      sample_q      <= sample_d;
      mask_q        <= mask_d;
      shift_q       <= shift_d;
      mag_q         <= mag_d;
      tmo_cnt_q     <= tmo_cnt_d;
      for (int k = 0; k < NUM_BANDS; k++) freq_q[k] <= freq_d[k];
      audio_out_q   <= audio_out_d;
      audio_valid_q <= audio_valid_d;
      eng_start_q   <= eng_start_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign eng_start   = eng_start_q;
  assign eng_band    = band_q;
  assign eng_sample  = sample_q;
  assign freq1       = freq_q[0];
  assign freq2       = freq_q[1];
  assign freq3       = freq_q[2];
  assign freq4       = freq_q[3];
  assign freq5       = freq_q[4];
  assign freq6       = freq_q[5];
  assign freq7       = freq_q[6];
  assign audio_out   = audio_out_q;
  assign audio_valid = audio_valid_q;
  assign busy        = (state_q != ST_IDLE);
  assign overrun_cnt = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_band_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_band_scheduler                                            |
// | Description : Scoreboard bench for band_scheduler with an engine model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_band_scheduler;

  localparam int SW  = 18;
  localparam int TMO = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          ready = 1'b0;
  logic [SW-1:0] audio_in = '0;
  logic [9:0]    controls = '0;
  logic          eng_done = 1'b0;
  logic [7:0]    eng_mag = '0;
  logic          eng_start;
  logic [2:0]    eng_band;
  logic [SW-1:0] eng_sample;
  logic [7:0]    freq1, freq2, freq3, freq4, freq5, freq6, freq7;
  logic [SW-1:0] audio_out;
  logic          audio_valid, busy, timeout_err;
  logic [7:0]    overrun_cnt;
  logic [7:0]    fr [7];

  assign fr[0] = freq1; assign fr[1] = freq2; assign fr[2] = freq3; assign fr[3] = freq4;
  assign fr[4] = freq5; assign fr[5] = freq6; assign fr[6] = freq7;

  band_scheduler #(.TIMEOUT_CYCLES(TMO), .SAMPLE_W(SW)) dut (
    .clock(clock), .reset_n(reset_n), .ready(ready), .audio_in(audio_in), .controls(controls),
    .eng_start(eng_start), .eng_band(eng_band), .eng_sample(eng_sample),
    .eng_done(eng_done), .eng_mag(eng_mag),
    .freq1(freq1), .freq2(freq2), .freq3(freq3), .freq4(freq4), .freq5(freq5), .freq6(freq6), .freq7(freq7),
    .audio_out(audio_out), .audio_valid(audio_valid), .busy(busy),
    .overrun_cnt(overrun_cnt), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Engine behaviour shared by stimulus and the engine model.
  int       eng_lat = 3;
  int       silent_band = -1;
  int       epoch = 0;
  logic [7:0] mag_tab [7];
  int       started_q [$];

  // Reference state: displayed level per band, computed from the peak-hold rule.
  int       mdl [7];

  typedef struct packed {
    logic [SW-1:0] sample;
    logic [6:0]    mask;
    logic [55:0]   freq;
  } exp_t;
  exp_t exp_q [$];

  int frames_seen = 0;
  int valid_cyc = 0;
  int ready_cyc = 0;

  // Engine model: answers each start after eng_lat cycles unless silenced.
  initial begin : engine
    int b;
    int ep;
    forever begin
      @(negedge clock);
      if (reset_n && eng_start) begin
        b  = int'(eng_band);
        ep = epoch;
        started_q.push_back(b);
        repeat (eng_lat) @(posedge clock);
        #1;
        if (ep == epoch && b != silent_band && reset_n) begin
          eng_done = 1'b1;
          eng_mag  = mag_tab[b];
          @(posedge clock);
          #1;
          eng_done = 1'b0;
          eng_mag  = '0;
        end
      end
    end
  end

  // Monitor: every completed frame is compared against the oldest prediction.
  initial begin : monitor
    exp_t e;
    logic [6:0] seen;
    int order_ok;
    forever begin
      @(negedge clock);
      if (reset_n && audio_valid) begin
        frames_seen++;
        valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got audio_out=%0d expected no frame", audio_out);
        end else begin
          e = exp_q.pop_front();
          check("audio_out", audio_out, e.sample);
          for (int k = 0; k < 7; k++) check($sformatf("freq%0d", k + 1), fr[k], e.freq[8*k +: 8]);
          seen = '0;
          order_ok = 1;
          foreach (started_q[i]) begin
            seen[started_q[i]] = 1'b1;
            if (i > 0 && started_q[i] <= started_q[i-1]) order_ok = 0;
          end
          check("bands_started", seen, e.mask);
          check("band_order", order_ok, 1);
        end
        started_q.delete();
      end
    end
  end

  function automatic exp_t predict(input logic [SW-1:0] s, input logic [6:0] mask, input int sh);
    exp_t e;
    int m, d;
    e.sample = s;
    e.mask   = mask;
    e.freq   = '0;
    for (int k = 0; k < 7; k++) begin
      if (mask[k]) begin
        m = (k == silent_band) ? 0 : int'(mag_tab[k]);
        d = mdl[k] - (mdl[k] / (1 << sh));
        mdl[k] = (m > d) ? m : d;
      end else begin
        mdl[k] = 0;
      end
      e.freq[8*k +: 8] = 8'(mdl[k]);
    end
    return e;
  endfunction

  task automatic pulse_ready(input logic [SW-1:0] s, input logic [9:0] c);
    @(posedge clock); #1;
    ready = 1'b1; audio_in = s; controls = c; ready_cyc = cyc;
    @(posedge clock); #1;
    ready = 1'b0;
  endtask

  task automatic start_frame(input logic [SW-1:0] s, input logic [6:0] mask, input int sh);
    exp_q.push_back(predict(s, mask, sh));
    pulse_ready(s, {3'(sh), mask});
  endtask

  task automatic wait_frame(input int budget);
    int n0;
    int i;
    n0 = frames_seen;
    i = 0;
    while (frames_seen == n0 && i < budget) begin
      @(posedge clock);
      i++;
    end
    if (frames_seen == n0) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: got no audio_valid after %0d cycles expected one", budget);
    end
    @(posedge clock); #1;
  endtask

  initial begin : stim
    logic [6:0] rmask;
    int n;
    for (int k = 0; k < 7; k++) begin mdl[k] = 0; mag_tab[k] = '0; end

    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_audio_valid", audio_valid, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_overrun", overrun_cnt, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_freq1", freq1, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // A stray engine completion while idle must not start anything.
    eng_done = 1'b1; eng_mag = 8'd99;
    @(posedge clock); #1;
    eng_done = 1'b0; eng_mag = '0;
    @(posedge clock); #1;
    check("stray_done_busy", busy, 0);
    check("stray_done_freq1", freq1, 0);

    // All bands, shift 0, mag 10*(band+1), latency 3.
    for (int k = 0; k < 7; k++) mag_tab[k] = 8'(10 * (k + 1));
    eng_lat = 3;
    start_frame(18'h2ABCD, 7'h7F, 0);
    wait_frame(200);
    check("latency_all_bands", valid_cyc - ready_cyc, 37);

    // Peak decay on band 3 with shift 1.
    mag_tab[2] = 8'd100;
    start_frame(18'h00011, 7'b0000100, 0);
    wait_frame(200);
    mag_tab[2] = 8'd20;
    start_frame(18'h00022, 7'b0000100, 1);
    wait_frame(200);
    check("decay_freq3", freq3, 50);
    mag_tab[2] = 8'd60;
    start_frame(18'h00033, 7'b0000100, 1);
    wait_frame(200);
    check("recover_freq3", freq3, 60);

    // Sparse mask: bands 0 and 2 only.
    for (int k = 0; k < 7; k++) mag_tab[k] = 8'(5 + 7 * k);
    start_frame(18'h1F00F, 7'b0000101, 0);
    wait_frame(200);

    // No band enabled goes straight to DONE.
    start_frame(18'h12345, 7'b0000000, 2);
    wait_frame(50);
    check("latency_no_bands", valid_cyc - ready_cyc, 2);

    // Second strobe at cycle 5 of a frame is dropped.
    start_frame(18'h0AAAA, 7'h7F, 0);
    repeat (3) @(posedge clock);
    #1;
    ready = 1'b1; audio_in = 18'h15555;
    @(posedge clock); #1;
    ready = 1'b0;
    wait_frame(200);
    check("overrun_one", overrun_cnt, 1);

    // Hammer ready through three long frames to saturate the counter.
    eng_lat = 14;
    for (int f = 0; f < 3; f++) begin
      start_frame(18'(f * 1000 + 7), 7'h7F, f);
      ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
        audio_in = 18'($urandom);
        @(posedge clock); #1;
      end
      ready = 1'b0;
      wait_frame(400);
    end
    check("overrun_saturated", overrun_cnt, 255);

    // Engine never answers band 4: forced through with magnitude 0.
    eng_lat = 3;
    check("timeout_err_clear", timeout_err, 0);
    silent_band = 4;
    start_frame(18'h3C3C3, 7'h7F, 0);
    wait_frame(400);
    check("timeout_err_set", timeout_err, 1);
    check("timeout_freq5", freq5, 0);
    silent_band = -1;

    // Randomised frames, controls scrambled while each frame runs.
    for (int f = 0; f < 24; f++) begin
      rmask = 7'($urandom);
      eng_lat = $urandom_range(1, 8);
      for (int k = 0; k < 7; k++) mag_tab[k] = 8'($urandom);
      start_frame(18'($urandom), rmask, $urandom_range(0, 7));
      controls = 10'($urandom);
      wait_frame(400);
    end

    // Reset asserted while waiting on the engine.
    for (int k = 0; k < 7; k++) mag_tab[k] = 8'd200;
    eng_lat = 10;
    start_frame(18'h2FFFF, 7'h7F, 0);
    wait_frame(400);
    start_frame(18'h1BEEF, 7'h7F, 3);
    n = 0;
    while (!eng_start && n < 20) begin @(posedge clock); #1; n++; end
    if (!eng_start) begin
      total++; bad++;
      $display("FAIL no_eng_start: got eng_start=0 expected 1");
    end
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_eng_start", eng_start, 0);
    check("mid_rst_eng_band", eng_band, 0);
    check("mid_rst_eng_sample", eng_sample, 0);
    check("mid_rst_audio_out", audio_out, 0);
    check("mid_rst_audio_valid", audio_valid, 0);
    check("mid_rst_freq1", freq1, 0);
    check("mid_rst_freq7", freq7, 0);
    check("mid_rst_overrun", overrun_cnt, 0);
    check("mid_rst_timeout_err", timeout_err, 0);
    epoch++;
    exp_q.delete();
    for (int k = 0; k < 7; k++) mdl[k] = 0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (15) @(posedge clock);
    started_q.delete();
    for (int k = 0; k < 7; k++) mag_tab[k] = 8'(3 * k + 1);
    eng_lat = 2;
    start_frame(18'h01234, 7'b1010011, 0);
    wait_frame(200);
    check("post_rst_latency", valid_cyc - ready_cyc, 4 * 4 + 2);

    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL leftover_frames: got %0d pending expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no completion expected finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
